load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: turns CPU load/store requests (byte, halfword, word; signed/unsigned) into word-wide memRead/memWrite transactions on the word-indexed data memory.
- Sub-word stores are done as read-modify-write.
- Sits between the datapath's MEM stage and dataMemory, with a valid/ready request port and a one-cycle response pulse.

Parameters:
DEPTH, 128, number of 32-bit words in the attached data memory
IDX_W, 7, word-index width (clog2 of DEPTH)

Ports:
CLK  in  1  clock; all state updates on posedge
RSTn  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request (high only in IDLE)
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as error)
req_unsigned  in  1  loads: zero-extend instead of sign-extend
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  load result, extended; 0 for stores and errors
resp_error  out  1  valid with resp_valid: misaligned, out-of-range, or reserved size
mem_address  out  32  word index, zero-extended from IDX_W bits
mem_writeData  out  32  full word to write
mem_memWrite  out  1  write enable; memory commits on negedge CLK
mem_memRead  out  1  read strobe; memory samples mem_address when this changes
mem_readData  in  32  word read from memory

Behaviour:
- Clock and reset: one clock, CLK. Reset RSTn is asynchronous and active-low.
- Reset values:
  - state = IDLE.
  - mem_memRead, mem_memWrite, resp_valid, resp_error = 0.
  - resp_rdata, mem_address, mem_writeData = 0.
  - Reset mid-operation drops the pending request. A write already committed on a negedge stays in memory.
- States: IDLE, ADDR, RD, WR, RESP. All memory-side outputs are registered.
- IDLE:
  - req_ready = 1.
  - On a posedge with req_valid = 1, latch write, size, unsigned, addr[1:0] and wdata.
  - Error check: half with addr[0] = 1, word with addr[1:0] != 0, size 11, or addr[31:2] >= DEPTH -> RESP with error = 1. No memory access.
  - Otherwise load mem_address = addr[IDX_W+1:2] and go to ADDR.
- ADDR: memRead = 0, memWrite = 0. mem_address holds stable one full cycle before any strobe. Next state is RD for loads and sub-word stores, WR for word stores.
- RD:
  - memRead = 1; this rising edge triggers the memory read.
  - At the next posedge, capture mem_readData.
  - Loads go to RESP with extracted data. Sub-word stores go to WR with the merged word.
- WR:
  - memWrite = 1, mem_writeData stable for the whole cycle; the memory writes on the negedge inside WR.
  - memWrite returns to 0 at the next posedge, then RESP.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE. resp_rdata/resp_error hold until the next RESP.
- Lane rules (little-endian):
  - Byte k = addr[1:0] occupies bits [8k+7:8k]. Halfword lane = addr[1].
  - Loads sign-extend from bit 7/15 unless req_unsigned. Word loads pass through.
  - Stores replace only the addressed lane(s) of the read word; all other bits are preserved.
- Latency, counted from the accept posedge to the posedge that raises resp_valid:
  - error: 1
  - load: 3
  - word store: 3
  - sub-word store: 4
- Throughput: one outstanding request. req_ready = 0 outside IDLE. req_valid held outside IDLE is ignored and is accepted only once back in IDLE.
- mem_memRead and mem_memWrite are never high in the same cycle. mem_memRead returns to 0 between consecutive reads so each read is a fresh edge.

Decomposition:
- Package lsu_pkg:
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD)
  - state enumeration
  - DEPTH/IDX_W defaults
- Sub-module lsu_lane_align (combinational), used by both the RD capture path and the WR data path:
  - load path: extract + extend
  - store path: merge of wdata into a read word
- FSM and registers stay in load_store_unit.

Test Plan:
- Reset mid-op: assert RSTn = 0 during RD -> memRead drops to 0 immediately, state IDLE, resp_valid never pulses, req_ready = 1 after release.
- Word store + load: store 0xDEADBEEF to 0x10, then load word 0x10 -> memWrite pulse with mem_address = 4 and writeData 0xDEADBEEF; load returns 0xDEADBEEF, resp_error = 0, both with latency 3.
- Byte/half merge: word 0x10 = 0x11223344, store byte 0xAA to 0x12, then store half 0x5566 to 0x10 -> memory word 0x11AA5566; exactly one read and one write per store; latency 4.
- Sign/zero extension: word 0x8000FF80 at 0x20; load byte signed 0x20 -> 0xFFFFFF80; unsigned -> 0x00000080; half signed 0x22 -> 0xFFFF8000.
- Errors: half load at 0x21, word store at 0x22, load at 0x200 (index 128), size 11 -> resp_error = 1 and resp_rdata = 0 at latency 1; no memRead/memWrite activity; memory unchanged.
- Back-to-back: req_valid held high across two requests -> second accepted only in the cycle after RESP; req_ready low throughout the first request.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and defaults for the load/store unit.
// Size codes, FSM states and memory geometry.
package lsu_pkg;

    localparam int DEF_DEPTH = 128;
    localparam int DEF_IDX_W = 7;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_RD,
        S_WR,
        S_RESP
    } state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane steering: load extract/extend and store merge.
// Offsets arrive pre-validated, so halfwords only see 0 or 2.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        uns,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [31:0] shifted;
    logic [31:0] mask;
    logic [31:0] lanes;

    always_comb begin
        shifted   = rword >> {off, 3'b000};
        load_data = 32'h0;
        mask      = 32'h0;
        lanes     = 32'h0;
        unique case (size)
            SZ_BYTE: begin
                load_data = {{24{shifted[7] & ~uns}}, shifted[7:0]};
                mask      = 32'hFF << {off, 3'b000};
                lanes     = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                load_data = {{16{shifted[15] & ~uns}}, shifted[15:0]};
                mask      = off[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                lanes     = {2{wdata[15:0]}};
            end
            SZ_WORD: begin
                load_data = rword;
                mask      = 32'hFFFF_FFFF;
                lanes     = wdata;
            end
            default: mask = 32'h0;
        endcase
        store_word = (rword & ~mask) | (lanes & mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: CPU requests to word-wide memory transactions.
// Sub-word stores are read-modify-write; one request in flight.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int IDX_W = DEF_IDX_W
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writeData,
    output logic        mem_memWrite,
    output logic        mem_memRead,
    input  logic [31:0] mem_readData
);

    state_t      state;
    logic        wr_q;
    logic        uns_q;
    logic        err_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [31:0] load_data;
    logic [31:0] store_word;
    logic        bad;

    assign req_ready = (state == S_IDLE);

    assign bad = (req_addr[31:2] >= 30'(DEPTH))
               || (req_size == 2'b11)
               || (req_size == SZ_HALF && req_addr[0])
               || (req_size == SZ_WORD && req_addr[1:0] != 2'b00);

    lsu_lane_align u_align (
        .rword      (mem_readData),
        .wdata      (wdata_q),
        .size       (size_q),
        .off        (off_q),
        .uns        (uns_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state         <= S_IDLE;
            wr_q          <= 1'b0;
            uns_q         <= 1'b0;
            err_q         <= 1'b0;
            size_q        <= SZ_BYTE;
            off_q         <= 2'b00;
            wdata_q       <= 32'h0;
            rdata_q       <= 32'h0;
            resp_valid    <= 1'b0;
            resp_rdata    <= 32'h0;
            resp_error    <= 1'b0;
            mem_address   <= 32'h0;
            mem_writeData <= 32'h0;
            mem_memWrite  <= 1'b0;
            mem_memRead   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        wr_q    <= req_write;
                        uns_q   <= req_unsigned;
                        size_q  <= req_size;
                        off_q   <= req_addr[1:0];
                        wdata_q <= req_wdata;
                        err_q   <= bad;
                        rdata_q <= 32'h0;
                        if (bad) begin
                            state <= S_RESP;
                        end else begin
                            mem_address <= {{(32-IDX_W){1'b0}},
                                            req_addr[IDX_W+1:2]};
                            state       <= S_ADDR;
                        end
                    end
                end
                // Address has settled for a full cycle; now strobe.
                S_ADDR: begin
                    if (wr_q && size_q == SZ_WORD) begin
                        mem_writeData <= wdata_q;
                        mem_memWrite  <= 1'b1;
                        state         <= S_WR;
                    end else begin
                        mem_memRead <= 1'b1;
                        state       <= S_RD;
                    end
                end
                S_RD: begin
                    mem_memRead <= 1'b0;
                    if (wr_q) begin
                        mem_writeData <= store_word;
                        mem_memWrite  <= 1'b1;
                        state         <= S_WR;
                    end else begin
                        rdata_q <= load_data;
                        state   <= S_RESP;
                    end
                end
                S_WR: begin
                    mem_memWrite <= 1'b0;
                    state        <= S_RESP;
                end
                S_RESP: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= rdata_q;
                    resp_error <= err_q;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
